// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, transmitter state encoding and
// the baud divisor helper used by both the transmit and receive paths.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int clks_per_bit(input int clock_hz, input int baud);
    return (clock_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while
// empty are ignored, so there is no pass-through when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a serializer that
// sends frames LSB first, back-to-back with no idle gap between them.
//   state | meaning
//   IDLE  | line high, waiting for the FIFO to hold a byte
//   START | start bit (low) on the line
//   DATA  | data bits, shift_reg[0] on the line
//   STOP  | stop bit (high); pops the next byte directly if one is queued
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ   = 27_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [UART_DATA_BITS-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      uart_tx,
  output logic                      busy,
  output logic [CNT_W-1:0]          fifo_count
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_HZ, BAUD);
  localparam int BAUD_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and >= 2");
  end

  uart_tx_state_t            state;
  logic [BAUD_W-1:0]         baud_cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [UART_DATA_BITS-1:0] fifo_rd_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_pop;
  logic                      bit_end;

  assign in_ready = reset_n && !fifo_full;
  assign bit_end  = (baud_cnt == '0);
  assign fifo_pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign busy     = (state != IDLE) || !fifo_empty;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (in_valid && in_ready),
    .wr_data (in_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (fifo_pop) begin
            shift_reg <= fifo_rd_data;
            baud_cnt  <= BAUD_LOAD;
            uart_tx   <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= BAUD_LOAD;
            bit_idx  <= '0;
            uart_tx  <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_idx == LAST_BIT) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + IDX_W'(1);
              uart_tx   <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            // Chain straight into the next start bit when a byte is waiting.
            if (fifo_pop) begin
              shift_reg <= fifo_rd_data;
              baud_cnt  <= BAUD_LOAD;
              uart_tx   <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 10 clocks per bit with a 4-entry FIFO;
// a line monitor decodes frames and records their start cycles.
module tb_uart_tx_fifo;

  localparam int CLOCK_HZ   = 1_000_000;
  localparam int BAUD       = 100_000;
  localparam int FIFO_DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int pcyc = 0;

  logic [7:0] rx_q[$];
  bit         rx_ok_q[$];
  int         rx_start_q[$];

  bit         mon_active = 0;
  int         mon_off = 0;
  int         mon_start = 0;
  bit         mon_start_ok = 0;
  logic [7:0] mon_byte = '0;

  uart_tx_fifo #(
    .CLOCK_HZ   (CLOCK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) pcyc++;

  // Line receiver: offset 0 is the first low sample, bits sampled mid-period.
  always @(negedge clock) begin
    if (!reset_n) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1;
        mon_off = 0;
        mon_start = pcyc;
      end
    end else begin
      mon_off++;
      if (mon_off == 5) mon_start_ok = (uart_tx === 1'b0);
      if (mon_off >= 15 && mon_off <= 85 && (mon_off % 10) == 5)
        mon_byte[(mon_off - 15) / 10] = uart_tx;
      if (mon_off == 95) begin
        rx_q.push_back(mon_byte);
        rx_ok_q.push_back(mon_start_ok && (uart_tx === 1'b1));
        rx_start_q.push_back(mon_start);
      end
      if (mon_off == 99) mon_active = 0;
    end
  end

  task automatic wait_neg();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_ok_q.delete();
    rx_start_q.delete();
  endtask

  // Returns at the falling edge after the accepting rising edge.
  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 2000) begin
      wait_neg();
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL push_timeout byte=%h in_ready=%b want=1", b, in_ready);
    end
    wait_neg();
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      wait_neg();
      k++;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy !== 1'b0 || mon_active) && k < 3000) begin
      wait_neg();
      k++;
    end
    repeat (5) wait_neg();
  endtask

  task automatic test_reset();
    bit bad;
    in_valid = 1'b0;
    in_data = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) wait_neg();
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx got=%b want=1", uart_tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      wait_neg();
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL idle_hygiene got=line_or_busy_active want=idle"); end
    checks++;
    if (rx_q.size() != 0) begin errors++; $display("FAIL idle_frames got=%0d want=0", rx_q.size()); end
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic exp;
    int t0;
    b = 8'h55;
    clear_rx();
    push_byte(b);
    t0 = pcyc;
    for (int k = 0; k < 100; k++) begin
      wait_neg();
      if (k < 10) exp = 1'b0;
      else if (k < 90) exp = b[(k - 10) / 10];
      else exp = 1'b1;
      checks++;
      if (uart_tx !== exp) begin errors++; $display("FAIL single_line k=%0d got=%b want=%b", k, uart_tx, exp); end
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_t0+100 got=%b want=1", busy); end
    wait_neg();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_t0+101 got=%b want=0", busy); end
    checks++;
    if (rx_q.size() != 1) begin
      errors++; $display("FAIL single_frames got=%0d want=1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 8'h55 || !rx_ok_q[0]) begin errors++; $display("FAIL single_decode got=%h ok=%0d want=55 ok=1", rx_q[0], rx_ok_q[0]); end
      checks++;
      if (rx_start_q[0] - t0 != 1) begin errors++; $display("FAIL single_latency got=%0d want=1", rx_start_q[0] - t0); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    int t0;
    exp[0] = 8'hA3; exp[1] = 8'h0F; exp[2] = 8'hFF;
    wait_idle();
    clear_rx();
    push_byte(exp[0]);
    t0 = pcyc;
    push_byte(exp[1]);
    push_byte(exp[2]);
    checks++;
    if (fifo_count !== 3'd2) begin errors++; $display("FAIL b2b_count got=%0d want=2", fifo_count); end
    wait_rx(3, 400);
    checks++;
    if (rx_q.size() != 3) begin
      errors++; $display("FAIL b2b_frames got=%0d want=3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[i] !== exp[i] || !rx_ok_q[i]) begin errors++; $display("FAIL b2b_decode i=%0d got=%h ok=%0d want=%h", i, rx_q[i], rx_ok_q[i], exp[i]); end
      end
      checks++;
      if (rx_start_q[0] - t0 != 1) begin errors++; $display("FAIL b2b_latency got=%0d want=1", rx_start_q[0] - t0); end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rx_start_q[i] - rx_start_q[i-1] != 100) begin errors++; $display("FAIL b2b_spacing i=%0d got=%0d want=100", i, rx_start_q[i] - rx_start_q[i-1]); end
      end
    end
  endtask

  task automatic test_full_fifo();
    int t0;
    int acc;
    wait_idle();
    clear_rx();
    push_byte(8'h01);
    t0 = pcyc;
    for (int i = 2; i <= 5; i++) push_byte(8'(i));
    checks++;
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d want=4", fifo_count); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
    push_byte(8'h06);
    acc = pcyc;
    checks++;
    if (acc - t0 != 102) begin errors++; $display("FAIL full_accept_edge got=%0d want=102", acc - t0); end
    checks++;
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count_after got=%0d want=4", fifo_count); end
    wait_rx(6, 800);
    checks++;
    if (rx_q.size() != 6) begin
      errors++; $display("FAIL full_frames got=%0d want=6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rx_q[i] !== 8'(i + 1) || !rx_ok_q[i]) begin errors++; $display("FAIL full_decode i=%0d got=%h ok=%0d want=%h", i, rx_q[i], rx_ok_q[i], 8'(i + 1)); end
      end
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] exp [3];
    int t0;
    exp[0] = 8'h3C; exp[1] = 8'h96; exp[2] = 8'h5A;
    wait_idle();
    clear_rx();
    push_byte(exp[0]);
    t0 = pcyc;
    push_byte(exp[1]);
    while (pcyc < t0 + 100) wait_neg();
    checks++;
    if (fifo_count !== 3'd1) begin errors++; $display("FAIL pp_count_before got=%0d want=1", fifo_count); end
    push_byte(exp[2]);
    checks++;
    if (pcyc - t0 != 101) begin errors++; $display("FAIL pp_accept_edge got=%0d want=101", pcyc - t0); end
    checks++;
    if (fifo_count !== 3'd1) begin errors++; $display("FAIL pp_count_after got=%0d want=1", fifo_count); end
    wait_rx(3, 400);
    checks++;
    if (rx_q.size() != 3) begin
      errors++; $display("FAIL pp_frames got=%0d want=3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[i] !== exp[i] || !rx_ok_q[i]) begin errors++; $display("FAIL pp_decode i=%0d got=%h ok=%0d want=%h", i, rx_q[i], rx_ok_q[i], exp[i]); end
      end
      checks++;
      if (rx_start_q[2] - rx_start_q[1] != 100) begin errors++; $display("FAIL pp_spacing got=%0d want=100", rx_start_q[2] - rx_start_q[1]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    bit saw_low;
    wait_idle();
    clear_rx();
    push_byte(8'h00);
    t0 = pcyc;
    push_byte(8'hE7);
    while (pcyc < t0 + 45) wait_neg();
    checks++;
    if (uart_tx !== 1'b0 || fifo_count !== 3'd1) begin errors++; $display("FAIL mid_precheck got=tx%b cnt%0d want=tx0 cnt1", uart_tx, fifo_count); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx got=%b want=1", uart_tx); end
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_reset_count got=%0d want=0", fifo_count); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_in_ready got=%b want=0", in_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
    repeat (3) wait_neg();
    clear_rx();
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || uart_tx !== 1'b1) begin errors++; $display("FAIL mid_release got=rdy%b tx%b want=rdy1 tx1", in_ready, uart_tx); end
    saw_low = 0;
    for (int k = 0; k < 300; k++) begin
      wait_neg();
      if (uart_tx !== 1'b1 || busy !== 1'b0) saw_low = 1;
    end
    checks++;
    if (saw_low || rx_q.size() != 0) begin errors++; $display("FAIL mid_silence got=activity frames=%0d want=idle frames=0", rx_q.size()); end
    push_byte(8'hC5);
    t0 = pcyc;
    wait_rx(1, 200);
    checks++;
    if (rx_q.size() != 1) begin
      errors++; $display("FAIL mid_new_frames got=%0d want=1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 8'hC5 || !rx_ok_q[0] || rx_start_q[0] - t0 != 1) begin
        errors++; $display("FAIL mid_new_decode got=%h ok=%0d lat=%0d want=c5 ok=1 lat=1", rx_q[0], rx_ok_q[0], rx_start_q[0] - t0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_fifo();
    test_push_pop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
